mem_access: RTL and testbench

Memory-access stage of the AKARIN RISC-V pipeline. It consumes the execute-stage packet (`ex2memPkt`), holds it in its own pipeline register, and performs the data-memory load or store over a valid/ready request and response handshake. It produces `mem2wbPkt` for write-back and raises `busy_o` to the hazard unit while an access is in flight. It sits between the execute-stage ALU and the write-back stage.

---
 rtl/mem_access_pkg.sv | 53 +++++
 rtl/mem_access_lane_fmt.sv | 48 ++++
 rtl/mem_access.sv | 99 +++++++++
 tb/tb_mem_access.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and decode constants for the AKARIN memory-access stage.
// Holds the stage packets, the access FSM encoding and the alignment rule.
package mem_access_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_LANES = XLEN / 8;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst32;
    logic            instValid;
    logic [4:0]      destReg;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] storeData;
  } ex2memPkt;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst32;
    logic            instValid;
    logic [4:0]      destReg;
    logic [XLEN-1:0] res;
    logic            misalign;
  } mem2wbPkt;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // funct3[1:0] gives the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lane_fmt.sv
// Byte-lane formatting: store enables/data, load extract/extend, misalign flag.
// Purely combinational; the caller qualifies outputs with load/store decode.
module mem_lane_fmt
  import mem_access_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [XLEN-1:0]      store_data,
  input  logic [XLEN-1:0]      rdata,
  output logic [NUM_LANES-1:0] be,
  output logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      ld_data,
  output logic                 misalign
);

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LANE = 2'(i);
      // Byte stores replicate lane 0, half stores replicate the low half.
      assign be[i] = (funct3[1:0] == 2'b00) ? (addr_lo == LANE) :
                     (funct3[1:0] == 2'b01) ? (addr_lo[1] == LANE[1]) : 1'b1;
      assign wdata[i*8 +: 8] = (funct3[1:0] == 2'b00) ? store_data[7:0] :
                               (funct3[1:0] == 2'b01) ? store_data[(i%2)*8 +: 8] :
                                                        store_data[i*8 +: 8];
    end
  endgenerate

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign ld_b = rdata[8*addr_lo +: 8];
  assign ld_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = rdata;
    case (funct3)
      F3_LB:   ld_data = {{24{ld_b[7]}}, ld_b};
      F3_LH:   ld_data = {{16{ld_h[15]}}, ld_h};
      F3_LBU:  ld_data = {24'd0, ld_b};
      F3_LHU:  ld_data = {16'd0, ld_h};
      default: ld_data = rdata;
    endcase
  end

  assign misalign = is_misaligned(funct3, addr_lo);

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: pipeline register plus load/store handshake FSM.
// Outputs depend only on the register and FSM state, never on dmem_* inputs.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  ex2memPkt             ex2mem_i,
  output mem2wbPkt             mem2wb_o,
  output logic                 busy_o,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic [XLEN-1:0]      dmem_addr,
  output logic                 dmem_we,
  output logic [NUM_LANES-1:0] dmem_be,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_rsp_valid,
  input  logic [XLEN-1:0]      dmem_rdata
);

  ex2memPkt        pkt_q;
  mem_state_e      state_q, state_d;
  logic [XLEN-1:0] ld_q;

  logic            capture;
  logic            is_load_q, is_store_q, mis_q;
  logic [2:0]      f3_q;
  logic            in_go;

  logic [NUM_LANES-1:0] fmt_be;
  logic [XLEN-1:0]      fmt_wdata, fmt_ld;
  logic                 fmt_mis;

  assign busy_o  = (state_q == REQ) || (state_q == WAIT);
  assign capture = !stall && !busy_o;

  assign f3_q       = pkt_q.inst32[14:12];
  assign is_load_q  = pkt_q.inst32[6:0] == OP_LOAD;
  assign is_store_q = pkt_q.inst32[6:0] == OP_STORE;
  assign mis_q      = pkt_q.instValid && (is_load_q || is_store_q) && fmt_mis;

  // Decide the post-capture state from the incoming packet so REQ is
  // entered on the same edge that loads the register.
  assign in_go = ex2mem_i.instValid && is_mem_op(ex2mem_i.inst32[6:0]) &&
                 !is_misaligned(ex2mem_i.inst32[14:12], ex2mem_i.res[1:0]);

  mem_lane_fmt u_fmt (
    .funct3     (f3_q),
    .addr_lo    (pkt_q.res[1:0]),
    .store_data (pkt_q.storeData),
    .rdata      (dmem_rdata),
    .be         (fmt_be),
    .wdata      (fmt_wdata),
    .ld_data    (fmt_ld),
    .misalign   (fmt_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q   <= '0;
      state_q <= IDLE;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) pkt_q <= ex2mem_i;
      if (state_q == WAIT && dmem_rsp_valid) ld_q <= fmt_ld;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (capture) state_d = in_go ? REQ : IDLE;
      REQ:        if (dmem_req_ready) state_d = is_load_q ? WAIT : DONE;
      WAIT:       if (dmem_rsp_valid) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem2wb_o.pc        = pkt_q.pc;
    mem2wb_o.inst32    = pkt_q.inst32;
    mem2wb_o.instValid = pkt_q.instValid && !busy_o;
    mem2wb_o.misalign  = mis_q;
    mem2wb_o.res       = (state_q == DONE && is_load_q) ? ld_q : pkt_q.res;
    mem2wb_o.destReg   = pkt_q.destReg;
    if (!pkt_q.instValid || is_store_q || mis_q || busy_o) mem2wb_o.destReg = '0;
  end

  // Request fields come straight from the held register, so they are
  // stable for the whole REQ interval.
  assign dmem_req_valid = state_q == REQ;
  assign dmem_addr      = {pkt_q.res[XLEN-1:2], 2'b00};
  assign dmem_we        = dmem_req_valid && is_store_q;
  assign dmem_be        = dmem_req_valid ? fmt_be : '0;
  assign dmem_wdata     = fmt_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access with hand-computed expectations.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall;
  ex2memPkt    ex2mem_i;
  mem2wbPkt    mem2wb_o;
  logic        busy_o, dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .stall(stall), .ex2mem_i(ex2mem_i), .mem2wb_o(mem2wb_o),
    .busy_o(busy_o), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] sd);
    ex2mem_i.pc        = 32'h0000_1000;
    ex2mem_i.inst32    = {7'd0, 5'd2, 5'd1, f3, rd, op};
    ex2mem_i.instValid = 1'b1;
    ex2mem_i.destReg   = rd;
    ex2mem_i.res       = res;
    ex2mem_i.storeData = sd;
  endtask

  task automatic bubble;
    ex2mem_i = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; bubble();
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    tick(); tick();
    checks++; if (mem2wb_o.instValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", mem2wb_o.instValid); end
    checks++; if (mem2wb_o.destReg !== 5'd0) begin errors++; $display("FAIL rst_dest got %0d exp 0", mem2wb_o.destReg); end
    checks++; if (mem2wb_o.misalign !== 1'b0) begin errors++; $display("FAIL rst_mis got %b exp 0", mem2wb_o.misalign); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", dmem_req_valid); end
    rst = 1'b0;
  endtask

  task automatic test_alu;
    set_ex(7'b0110011, 3'b000, 5'd3, 32'h1234, 32'h0);
    tick(); bubble();
    checks++; if (mem2wb_o.instValid !== 1'b1) begin errors++; $display("FAIL alu_valid got %b exp 1", mem2wb_o.instValid); end
    checks++; if (mem2wb_o.res !== 32'h1234) begin errors++; $display("FAIL alu_res got %h exp 00001234", mem2wb_o.res); end
    checks++; if (mem2wb_o.destReg !== 5'd3) begin errors++; $display("FAIL alu_dest got %0d exp 3", mem2wb_o.destReg); end
    checks++; if (busy_o !== 1'b0 || dmem_req_valid !== 1'b0) begin errors++; $display("FAIL alu_busy got %b%b exp 00", busy_o, dmem_req_valid); end
    tick();
    checks++; if (mem2wb_o.instValid !== 1'b0) begin errors++; $display("FAIL alu_bubble got %b exp 0", mem2wb_o.instValid); end
  endtask

  task automatic test_store;
    dmem_req_ready = 1'b1;
    set_ex(OP_STORE, F3_SB, 5'd5, 32'h103, 32'h1234_56A5);
    tick(); bubble();
    checks++; if (dmem_req_valid !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL sb_req got %b%b exp 11", dmem_req_valid, busy_o); end
    checks++; if (mem2wb_o.instValid !== 1'b0) begin errors++; $display("FAIL sb_busyvalid got %b exp 0", mem2wb_o.instValid); end
    checks++; if (dmem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", dmem_be); end
    checks++; if (dmem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", dmem_wdata); end
    checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL sb_we got %b exp 1", dmem_we); end
    checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL sb_addr got %h exp 00000100", dmem_addr); end
    tick();
    checks++; if (busy_o !== 1'b0 || dmem_req_valid !== 1'b0) begin errors++; $display("FAIL sb_done got %b%b exp 00", busy_o, dmem_req_valid); end
    checks++; if (mem2wb_o.instValid !== 1'b1) begin errors++; $display("FAIL sb_valid got %b exp 1", mem2wb_o.instValid); end
    checks++; if (mem2wb_o.destReg !== 5'd0) begin errors++; $display("FAIL sb_dest got %0d exp 0", mem2wb_o.destReg); end
    set_ex(OP_STORE, F3_SH, 5'd6, 32'h202, 32'h1234_BEEF);
    tick(); bubble();
    checks++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", dmem_be); end
    checks++; if (dmem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", dmem_wdata); end
    tick(); tick();
    dmem_req_ready = 1'b0;
  endtask

  task automatic run_byte_load(input logic [2:0] f3, input logic [31:0] exp_res, input string nm);
    int n;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h0080_0000;
    set_ex(OP_LOAD, f3, 5'd7, 32'h102, 32'h0);
    tick(); bubble();
    n = 0;
    while (busy_o && n < 20) begin
      n++;
      dmem_req_ready = (n >= 3);
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL %s_busycycles got %0d exp 4", nm, n); end
    checks++; if (mem2wb_o.instValid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b exp 1", nm, mem2wb_o.instValid); end
    checks++; if (mem2wb_o.res !== exp_res) begin errors++; $display("FAIL %s_res got %h exp %h", nm, mem2wb_o.res, exp_res); end
    checks++; if (mem2wb_o.destReg !== 5'd7) begin errors++; $display("FAIL %s_dest got %0d exp 7", nm, mem2wb_o.destReg); end
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    tick();
  endtask

  task automatic test_load;
    run_byte_load(F3_LB, 32'hFFFF_FF80, "lb");
    run_byte_load(F3_LBU, 32'h0000_0080, "lbu");
  endtask

  task automatic test_misalign;
    dmem_req_ready = 1'b1;
    set_ex(OP_LOAD, F3_LW, 5'd9, 32'h106, 32'h0);
    tick(); bubble();
    checks++; if (mem2wb_o.misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", mem2wb_o.misalign); end
    checks++; if (mem2wb_o.destReg !== 5'd0) begin errors++; $display("FAIL mis_dest got %0d exp 0", mem2wb_o.destReg); end
    checks++; if (busy_o !== 1'b0 || dmem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_req got %b%b exp 00", busy_o, dmem_req_valid); end
    checks++; if (mem2wb_o.res !== 32'h106) begin errors++; $display("FAIL mis_res got %h exp 00000106", mem2wb_o.res); end
    tick();
    dmem_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
    set_ex(OP_LOAD, F3_LH, 5'd4, 32'h200, 32'h0);
    tick(); bubble();
    tick();
    checks++; if (busy_o !== 1'b1 || dmem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_wait got %b%b exp 10", busy_o, dmem_req_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (dmem_req_valid !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rm_idle got %b%b exp 00", dmem_req_valid, busy_o); end
    checks++; if (mem2wb_o.instValid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", mem2wb_o.instValid); end
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick();
    checks++; if (mem2wb_o.instValid !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rm_late got %b%b exp 00", mem2wb_o.instValid, busy_o); end
    dmem_rsp_valid = 1'b0; dmem_req_ready = 1'b0;
  endtask

  task automatic test_stall;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFE_BABE;
    set_ex(OP_LOAD, F3_LW, 5'd6, 32'h300, 32'h0);
    tick(); bubble();
    tick();
    stall = 1'b1;
    set_ex(7'b0110011, 3'b000, 5'd8, 32'h55, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (mem2wb_o.res !== 32'hCAFE_BABE || mem2wb_o.instValid !== 1'b1 || mem2wb_o.destReg !== 5'd6 || busy_o !== 1'b0)
        begin errors++; $display("FAIL stall_hold%0d got %h/%b/%0d/%b exp cafebabe/1/6/0", k, mem2wb_o.res, mem2wb_o.instValid, mem2wb_o.destReg, busy_o); end
    end
    stall = 1'b0;
    tick(); bubble();
    checks++; if (mem2wb_o.res !== 32'h55 || mem2wb_o.destReg !== 5'd8) begin errors++; $display("FAIL stall_next got %h/%0d exp 00000055/8", mem2wb_o.res, mem2wb_o.destReg); end
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_misalign();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
